// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light status display:
// lamp-select codes, active-low segment patterns and digit-select constants.
package traffic_pkg;

    localparam logic [2:0] CTRL_IDLE = 3'b000;
    localparam logic [2:0] CTRL_G    = 3'b001;
    localparam logic [2:0] CTRL_Y    = 3'b010;
    localparam logic [2:0] CTRL_R    = 3'b100;

    // Segment patterns are {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    localparam logic [1:0] SEL_ONES = 2'b10;
    localparam logic [1:0] SEL_TENS = 2'b01;
    localparam logic [1:0] SEL_NONE = 2'b11;

    typedef enum logic {
        DIG_ONES = 1'b0,
        DIG_TENS = 1'b1
    } digit_e;

endpackage

// File: rtl/traffic_display_seg7_decode.sv
// Combinational 7-segment decoder: dash overrides blank, blank overrides digit.
// Digit values above 9 decode to blank.
module seg7_decode
    import traffic_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    logic [6:0] code;

    always_comb begin
        code = SEG_BLANK;
        case (digit)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
    end

    always_comb begin
        seg = code;
        if (dash)
            seg = SEG_DASH;
        else if (blank)
            seg = SEG_BLANK;
    end

endmodule

// File: rtl/traffic_display.sv
// Lamp driver, multiplexed two-digit countdown and interface checker
// for the traffic-light controller status bus.
module traffic_display
    import traffic_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV  = 16'd50000,
    parameter logic [25:0] BLINK_DIV = 26'd25000000,
    parameter logic [4:0]  WARN_T    = 5'd3,
    parameter logic [4:0]  T_MAX     = 5'd15
) (
    input  logic       sys_clk,
    input  logic       sys_rst_p,
    input  logic [4:0] light_t,
    input  logic [2:0] light_ctrl,
    input  logic       err_clr,
    output logic       led_g,
    output logic       led_y,
    output logic       led_r,
    output logic [1:0] seg_sel,
    output logic [7:0] seg_data,
    output logic       err
);

    logic [4:0]  t_q;
    logic [2:0]  c_q;
    logic [15:0] scan_cnt;
    logic [25:0] blink_cnt;
    logic        blink;
    digit_e      dsel;

    logic       ctrl_ok;
    logic       viol;
    logic       idle;
    logic       warn;
    logic [1:0] tens;
    logic [4:0] rem;
    logic [3:0] ones;
    logic [3:0] cur_digit;
    logic       cur_blank;
    logic [6:0] seg_next;

    always_comb begin
        ctrl_ok = (c_q == CTRL_IDLE) || (c_q == CTRL_G) ||
                  (c_q == CTRL_Y) || (c_q == CTRL_R);
        viol = !ctrl_ok || (t_q > T_MAX) ||
               ((c_q != CTRL_IDLE) && (t_q == 5'd0));
        idle = (c_q == CTRL_IDLE) && !viol;
        warn = (t_q <= WARN_T) && blink;
    end

    // Compare-subtract split; t_q is at most 31 so tens fits in 2 bits
    always_comb begin
        rem  = t_q;
        tens = 2'd0;
        if (rem >= 5'd30) begin
            tens = 2'd3;
            rem  = rem - 5'd30;
        end else if (rem >= 5'd20) begin
            tens = 2'd2;
            rem  = rem - 5'd20;
        end else if (rem >= 5'd10) begin
            tens = 2'd1;
            rem  = rem - 5'd10;
        end
        ones = rem[3:0];
    end

    always_comb begin
        cur_digit = (dsel == DIG_ONES) ? ones : {2'b00, tens};
        cur_blank = idle || ((dsel == DIG_TENS) && (tens == 2'd0));
    end

    seg7_decode u_dec (
        .digit (cur_digit),
        .blank (cur_blank),
        .dash  (viol),
        .seg   (seg_next)
    );

    always_ff @(posedge sys_clk or posedge sys_rst_p) begin
        if (sys_rst_p) begin
            t_q       <= '0;
            c_q       <= '0;
            scan_cnt  <= '0;
            blink_cnt <= '0;
            blink     <= 1'b0;
            dsel      <= DIG_ONES;
            err       <= 1'b0;
            led_g     <= 1'b0;
            led_y     <= 1'b0;
            led_r     <= 1'b0;
            seg_sel   <= SEL_NONE;
            seg_data  <= 8'hFF;
        end else begin
            t_q <= light_t;
            c_q <= light_ctrl;

            if (scan_cnt == SCAN_DIV - 16'd1) begin
                scan_cnt <= '0;
                dsel     <= (dsel == DIG_ONES) ? DIG_TENS : DIG_ONES;
            end else begin
                scan_cnt <= scan_cnt + 16'd1;
            end

            if (blink_cnt == BLINK_DIV - 26'd1) begin
                blink_cnt <= '0;
                blink     <= !blink;
            end else begin
                blink_cnt <= blink_cnt + 26'd1;
            end

            // A live violation takes priority over a clear request
            if (viol)
                err <= 1'b1;
            else if (err_clr)
                err <= 1'b0;

            led_g <= !viol && c_q[0] && !warn;
            led_y <= !viol && c_q[1];
            led_r <= !viol && c_q[2];

            seg_sel  <= (dsel == DIG_ONES) ? SEL_ONES : SEL_TENS;
            seg_data <= {1'b1, seg_next};
        end
    end

endmodule
